main_mem_arbiter: RTL

Shares the single-port 128-bit block main memory (`wrapper_ram`) between two requesters: port 0 (CPU `iomem` bus) and port 1 (program loader / debug DMA). It arbitrates round-robin, decodes the RAM window, and sequences each access through the fixed RAM latency. It also returns the completion handshake, replacing the ad-hoc ready shift register in the top-level wrapper.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_rr2.sv | 20 ++
 rtl/main_mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, default constants and RAM window decode for the main memory arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } mem_arb_state_e;

   localparam int unsigned DEF_BLOCK_SIZE    = 128;
   localparam int unsigned DEF_RAM_DELAY     = 16;
   localparam logic [31:0] DEF_RAM_BASE_ADDR = 32'h4000_0000;
   localparam logic [31:0] DEF_RAM_MASK_ADDR = 32'h000f_ffff;

   function automatic logic in_ram_window(input logic [31:0] addr,
                                          input logic [31:0] base = DEF_RAM_BASE_ADDR,
                                          input logic [31:0] mask = DEF_RAM_MASK_ADDR);
      return (addr & ~mask) == base;
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant; on a tie the port that did not win last time is chosen.
module mem_arb_rr2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt    = '0;
      gnt_id = 1'b0;
      if (en) begin
         if (req == 2'b11) gnt_id = ~last_grant;
         else              gnt_id = req[1];
         if (|req) gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing the 128-bit block RAM between the CPU bus and the loader/DMA port.
module main_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE    = DEF_BLOCK_SIZE,
   parameter int unsigned NUMS_BYTE     = BLOCK_SIZE/8,
   parameter int unsigned RAM_DELAY     = DEF_RAM_DELAY,
   parameter logic [31:0] RAM_BASE_ADDR = DEF_RAM_BASE_ADDR,
   parameter logic [31:0] RAM_MASK_ADDR = DEF_RAM_MASK_ADDR,
   parameter int unsigned RAM_AW        = 13
) (
   input  logic                  clk_o,
   input  logic                  rst_n,
   input  logic                  m0_valid,
   input  logic [31:0]           m0_addr,
   input  logic [NUMS_BYTE-1:0]  m0_wstrb,
   input  logic [BLOCK_SIZE-1:0] m0_wdata,
   input  logic                  m1_valid,
   input  logic [31:0]           m1_addr,
   input  logic [NUMS_BYTE-1:0]  m1_wstrb,
   input  logic [BLOCK_SIZE-1:0] m1_wdata,
   output logic                  m0_ready,
   output logic                  m1_ready,
   output logic [BLOCK_SIZE-1:0] m_rdata,
   output logic                  m_err,
   output logic [RAM_AW-1:0]     ram_addr,
   output logic [BLOCK_SIZE-1:0] ram_wdata,
   output logic [NUMS_BYTE-1:0]  ram_wstrb,
   output logic                  ram_rd_en,
   input  logic [BLOCK_SIZE-1:0] ram_rdata,
   output logic                  busy
);

   localparam int unsigned CW       = $clog2(RAM_DELAY);
   localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_DELAY - 2);

   mem_arb_state_e        state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic                  last_grant_q;
   logic                  gnt_id_q;
   logic [RAM_AW-1:0]     addr_q;
   logic [NUMS_BYTE-1:0]  wstrb_q;
   logic [BLOCK_SIZE-1:0] wdata_q;
   logic [BLOCK_SIZE-1:0] rdata_q;

   logic [1:0]            gnt;
   logic                  gnt_id;
   logic [31:0]           sel_addr;
   logic                  hit;

   mem_arb_rr2 u_rr2 (
      .req        ({m1_valid, m0_valid}),
      .last_grant (last_grant_q),
      .en         (state_q == ST_IDLE),
      .gnt        (gnt),
      .gnt_id     (gnt_id)
   );

   assign sel_addr = gnt[1] ? m1_addr : m0_addr;
   assign hit      = in_ram_window(sel_addr, RAM_BASE_ADDR, RAM_MASK_ADDR);

   always_comb begin
      state_d   = state_q;
      ram_rd_en = 1'b0;
      ram_wstrb = '0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;
      m_err     = 1'b0;
      busy      = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: if (|gnt) state_d = hit ? ST_ISSUE : ST_ERR;
         ST_ISSUE: begin
            ram_rd_en = ~|wstrb_q;
            ram_wstrb = wstrb_q;
            state_d   = ST_WAIT;
         end
         ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE: begin
            m0_ready = ~gnt_id_q;
            m1_ready = gnt_id_q;
            state_d  = ST_IDLE;
         end
         ST_ERR: begin
            m0_ready = ~gnt_id_q;
            m1_ready = gnt_id_q;
            m_err    = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_o) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         gnt_id_q     <= 1'b0;
         addr_q       <= '0;
         wstrb_q      <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE: if (|gnt) begin
               gnt_id_q     <= gnt_id;
               last_grant_q <= gnt_id;
               addr_q       <= sel_addr[RAM_AW+3:4];
               wstrb_q      <= gnt[1] ? m1_wstrb : m0_wstrb;
               wdata_q      <= gnt[1] ? m1_wdata : m0_wdata;
               // Clearing here makes the read data zero during the ERR pulse.
               if (!hit) rdata_q <= '0;
            end
            ST_ISSUE: cnt_q <= CNT_LOAD;
            ST_WAIT: begin
               // RAM data from the ISSUE read is present on the first WAIT cycle only.
               if (cnt_q == CNT_LOAD && wstrb_q == '0) rdata_q <= ram_rdata;
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign m_rdata   = rdata_q;

endmodule
